// File: rtl/blake2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blake2_pkg
//  Description : Shared types and constants for the BLAKE2 G / inverse-G
//                iterative cores: FSM state encoding, step index type and the
//                G rotation amounts for BLAKE2s and BLAKE2b.
//  Revision    : 1.0  initial release
// ============================================================================
package blake2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [2:0] step_t;

    localparam step_t LAST_STEP = 3'd7;

    // BLAKE2s (W=32) rotation amounts
    localparam int BLAKE2S_R1 = 16;
    localparam int BLAKE2S_R2 = 12;
    localparam int BLAKE2S_R3 = 8;
    localparam int BLAKE2S_R4 = 7;

    // BLAKE2b (W=64) rotation amounts
    localparam int BLAKE2B_R1 = 32;
    localparam int BLAKE2B_R2 = 24;
    localparam int BLAKE2B_R3 = 16;
    localparam int BLAKE2B_R4 = 63;

endpackage
`default_nettype wire

// File: rtl/blake2_g_inv_if.sv
`default_nettype none
// ============================================================================
//  Module      : blake2_g_inv_if
//  Description : Job interface of the iterative G / inverse-G block: an input
//                valid/ready handshake carrying a,b,c,d,x,y and an output
//                valid/ready handshake carrying the four result words.
//                Signal directions are named from the block's point of view.
//                Optional macro: BLAKE2_G_INV_FWD_EN adds the fwd_i select.
//  Revision    : 1.0  initial release
// ============================================================================
interface blake2_g_inv_if #(
    parameter int W = 32
);
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic [W-1:0] c_i;
    logic [W-1:0] d_i;
    logic [W-1:0] x_i;
    logic [W-1:0] y_i;
`ifdef BLAKE2_G_INV_FWD_EN
    logic         fwd_i;
`endif
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] a_o;
    logic [W-1:0] b_o;
    logic [W-1:0] c_o;
    logic [W-1:0] d_o;

`ifdef BLAKE2_G_INV_FWD_EN
    modport slave (
        input  valid_i, a_i, b_i, c_i, d_i, x_i, y_i, fwd_i, ready_i,
        output ready_o, valid_o, a_o, b_o, c_o, d_o
    );
    modport master (
        output valid_i, a_i, b_i, c_i, d_i, x_i, y_i, fwd_i, ready_i,
        input  ready_o, valid_o, a_o, b_o, c_o, d_o
    );
`else
    modport slave (
        input  valid_i, a_i, b_i, c_i, d_i, x_i, y_i, ready_i,
        output ready_o, valid_o, a_o, b_o, c_o, d_o
    );
    modport master (
        output valid_i, a_i, b_i, c_i, d_i, x_i, y_i, ready_i,
        input  ready_o, valid_o, a_o, b_o, c_o, d_o
    );
`endif

endinterface
`default_nettype wire

// File: rtl/blake2_rotl.sv
`default_nettype none
// ============================================================================
//  Module      : blake2_rotl
//  Description : Constant left rotate of a W-bit word by ROT_I bits (pure
//                wiring). A rotation that is a multiple of W is a pass-through.
//  Revision    : 1.0  initial release
// ============================================================================
module blake2_rotl #(
    parameter int ROT_I = 7,
    parameter int W     = 32
) (
    input  wire logic [W-1:0] data_i,
    output logic      [W-1:0] data_o
);

    localparam int ROT_N = ROT_I % W;

    generate
        if (ROT_N == 0) begin : g_pass
            assign data_o = data_i;
        end else begin : g_rot
            assign data_o = {data_i[W-ROT_N-1:0], data_i[W-1:W-ROT_N]};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/blake2_g_inv.sv
`default_nettype none
// ============================================================================
//  Module      : blake2_g_inv
//  Description : Iterative inverse of the BLAKE2 G mixing function. Recovers
//                G's four input words from its four output words and the
//                message words x,y, one reverse step per clock (8 steps).
//                Optional macro: BLAKE2_G_INV_FWD_EN adds fwd_i, which runs
//                forward G on the same datapath with identical latency.
//  Revision    : 1.0  initial release
// ============================================================================
module blake2_g_inv
    import blake2_pkg::*;
#(
    parameter int W  = 32,
    parameter int R1 = BLAKE2S_R1,
    parameter int R2 = BLAKE2S_R2,
    parameter int R3 = BLAKE2S_R3,
    parameter int R4 = BLAKE2S_R4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    blake2_g_inv_if.slave  bus
);

    state_t       state_q;
    step_t        step_q;
    logic         last_q;     // all eight steps executed; next RUN cycle enters DONE
    logic         ready_q;
    logic         valid_q;
    logic [W-1:0] a_q, b_q, c_q, d_q;
    logic [W-1:0] x_q, y_q;
    logic [W-1:0] a_d, b_d, c_d, d_d;
    logic [W-1:0] inv_a, inv_b, inv_c, inv_d;

    // Rotated operands for the inverse steps, one rotator per amount
    logic [W-1:0] rot_b_r4, rot_d_r3, rot_b_r2, rot_d_r1;

    blake2_rotl #(.ROT_I(R4), .W(W)) u_rotl_r4 (.data_i(b_q), .data_o(rot_b_r4));
    blake2_rotl #(.ROT_I(R3), .W(W)) u_rotl_r3 (.data_i(d_q), .data_o(rot_d_r3));
    blake2_rotl #(.ROT_I(R2), .W(W)) u_rotl_r2 (.data_i(b_q), .data_o(rot_b_r2));
    blake2_rotl #(.ROT_I(R1), .W(W)) u_rotl_r1 (.data_i(d_q), .data_o(rot_d_r1));

    // Reverse G: each step rewrites exactly one working word
    always_comb begin
        inv_a = a_q;
        inv_b = b_q;
        inv_c = c_q;
        inv_d = d_q;
        case (step_q)
            3'd0: inv_b = rot_b_r4 ^ c_q;
            3'd1: inv_c = c_q - d_q;
            3'd2: inv_d = rot_d_r3 ^ a_q;
            3'd3: inv_a = a_q - b_q - y_q;
            3'd4: inv_b = rot_b_r2 ^ c_q;
            3'd5: inv_c = c_q - d_q;
            3'd6: inv_d = rot_d_r1 ^ a_q;
            3'd7: inv_a = a_q - b_q - x_q;
        endcase
    end

`ifdef BLAKE2_G_INV_FWD_EN
    logic         fwd_q;
    logic [W-1:0] fwd_a, fwd_b, fwd_c, fwd_d;
    logic [W-1:0] da_x, bc_x;
    logic [W-1:0] rotr_da_r1, rotr_bc_r2, rotr_da_r3, rotr_bc_r4;

    assign da_x = d_q ^ a_q;
    assign bc_x = b_q ^ c_q;

    // Right rotate by R is a left rotate by W-R
    blake2_rotl #(.ROT_I(W-R1), .W(W)) u_rotr_r1 (.data_i(da_x), .data_o(rotr_da_r1));
    blake2_rotl #(.ROT_I(W-R2), .W(W)) u_rotr_r2 (.data_i(bc_x), .data_o(rotr_bc_r2));
    blake2_rotl #(.ROT_I(W-R3), .W(W)) u_rotr_r3 (.data_i(da_x), .data_o(rotr_da_r3));
    blake2_rotl #(.ROT_I(W-R4), .W(W)) u_rotr_r4 (.data_i(bc_x), .data_o(rotr_bc_r4));

    // Forward G on the same working registers
    always_comb begin
        fwd_a = a_q;
        fwd_b = b_q;
        fwd_c = c_q;
        fwd_d = d_q;
        case (step_q)
            3'd0: fwd_a = a_q + b_q + x_q;
            3'd1: fwd_d = rotr_da_r1;
            3'd2: fwd_c = c_q + d_q;
            3'd3: fwd_b = rotr_bc_r2;
            3'd4: fwd_a = a_q + b_q + y_q;
            3'd5: fwd_d = rotr_da_r3;
            3'd6: fwd_c = c_q + d_q;
            3'd7: fwd_b = rotr_bc_r4;
        endcase
    end

    assign a_d = fwd_q ? fwd_a : inv_a;
    assign b_d = fwd_q ? fwd_b : inv_b;
    assign c_d = fwd_q ? fwd_c : inv_c;
    assign d_d = fwd_q ? fwd_d : inv_d;
`else
    assign a_d = inv_a;
    assign b_d = inv_b;
    assign c_d = inv_c;
    assign d_d = inv_d;
`endif

    // Control FSM with registered handshake outputs and working registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
`ifdef BLAKE2_G_INV_FWD_EN
            fwd_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (bus.valid_i && ready_q) begin
                        a_q     <= bus.a_i;
                        b_q     <= bus.b_i;
                        c_q     <= bus.c_i;
                        d_q     <= bus.d_i;
                        x_q     <= bus.x_i;
                        y_q     <= bus.y_i;
`ifdef BLAKE2_G_INV_FWD_EN
                        fwd_q   <= bus.fwd_i;
`endif
                        step_q  <= '0;
                        last_q  <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (last_q) begin
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        a_q    <= a_d;
                        b_q    <= b_d;
                        c_q    <= c_d;
                        d_q    <= d_d;
                        step_q <= step_q + 3'd1;
                        if (step_q == LAST_STEP) begin
                            last_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.valid_o = valid_q;
    assign bus.a_o     = a_q;
    assign bus.b_o     = b_q;
    assign bus.c_o     = c_q;
    assign bus.d_o     = d_q;

endmodule
`default_nettype wire
